branch_resolve_unit: RTL and testbench

- Execute-stage block directly downstream of the branch comparator.
- Drives the comparator's unsigned-select, consumes its equal/less-than flags and decodes the branch/jump condition.
- Computes and validates the target, then issues a registered PC redirect plus a multi-cycle pipeline flush through a small FSM.
- Also produces the link value for JAL/JALR write-back and keeps branch performance counters.

---
 rtl/branch_resolve_unit.sv | 171 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Execute-stage branch/jump resolution. Decodes the branch
//               condition from comparator flags, computes the target and
//               issues a registered PC redirect with a multi-cycle flush.
//               Also produces JAL/JALR link values and keeps branch
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 branch_i,
  input  logic                 jal_i,
  input  logic                 jalr_i,
  input  logic [2:0]           funct3_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [XLEN-1:0]      imm_i,
  input  logic [XLEN-1:0]      rs1_i,
  output logic                 BrUn_o,
  input  logic                 BrEq_i,
  input  logic                 BrLt_i,
  output logic                 redirect_o,
  output logic [XLEN-1:0]      target_o,
  output logic                 flush_o,
  output logic                 link_valid_o,
  output logic [XLEN-1:0]      link_o,
  output logic                 misalign_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] br_cnt_o,
  output logic [CNT_WIDTH-1:0] taken_cnt_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Flush counter preload; the FLUSH state lasts this value + 1 cycles.
  localparam logic [3:0]           FCNT_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [3:0]          fcnt_q, fcnt_d;
  logic                redirect_q, link_valid_q, misalign_q, illegal_q;
  logic [XLEN-1:0]     target_q, link_q;
  logic [CNT_WIDTH-1:0] br_cnt_q, taken_cnt_q;

  logic                w_is_jal, w_is_jalr, w_is_br;
  logic                w_cond, w_bad_f3, w_taken;
  logic                w_accept, w_go, w_misalign, w_link;
  logic [XLEN-1:0]     w_base, w_sum, w_target, w_link_val;

  // Comparator select: funct3[1] distinguishes the unsigned compares.
  assign BrUn_o  = funct3_i[1];
  assign ready_o = (state_q == IDLE);
  assign flush_o = (state_q == FLUSH);

  // Instruction kind with jal > jalr > branch precedence.
  assign w_is_jal  = jal_i;
  assign w_is_jalr = ~jal_i & jalr_i;
  assign w_is_br   = ~jal_i & ~jalr_i & branch_i;

  // Branch condition decode from the comparator flags.
  always_comb begin
    w_cond   = 1'b0;
    w_bad_f3 = 1'b0;
    case (funct3_i)
      3'b000:          w_cond = BrEq_i;
      3'b001:          w_cond = ~BrEq_i;
      3'b100, 3'b110:  w_cond = BrLt_i;
      3'b101, 3'b111:  w_cond = ~BrLt_i;
      default:         w_bad_f3 = 1'b1;
    endcase
  end

  // Target: JALR uses rs1 as base and clears bit 0; others are PC-relative.
  assign w_base     = w_is_jalr ? rs1_i : pc_i;
  assign w_sum      = w_base + imm_i;
  assign w_target   = w_is_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
  assign w_link_val = pc_i + XLEN'(4);

  assign w_accept   = valid_i & ready_o;
  assign w_taken    = w_is_jal | w_is_jalr | (w_is_br & w_cond);
  assign w_misalign = w_accept & w_taken & w_target[1];
  assign w_go       = w_accept & w_taken & ~w_target[1];
  assign w_link     = w_go & (w_is_jal | w_is_jalr);

  // FSM next-state: enter FLUSH on a redirect, count down, return to IDLE.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (w_go) begin
          state_d = FLUSH;
          fcnt_d  = FCNT_INIT;
        end
      end
      FLUSH: begin
        if (fcnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = 4'd0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      fcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Registered response pulses, held target/link values and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redirect_q   <= 1'b0;
      link_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      illegal_q    <= 1'b0;
      target_q     <= '0;
      link_q       <= '0;
      br_cnt_q     <= '0;
      taken_cnt_q  <= '0;
    end else begin
      redirect_q   <= w_go;
      link_valid_q <= w_link;
      misalign_q   <= w_misalign;
      illegal_q    <= w_accept & w_is_br & w_bad_f3;
      if (w_go) begin
        target_q    <= w_target;
        taken_cnt_q <= taken_cnt_q + CNT_ONE;
      end
      if (w_link) begin
        link_q <= w_link_val;
      end
      if (w_accept & w_is_br) begin
        br_cnt_q <= br_cnt_q + CNT_ONE;
      end
    end
  end

  assign redirect_o   = redirect_q;
  assign target_o     = target_q;
  assign link_valid_o = link_valid_q;
  assign link_o       = link_q;
  assign misalign_o   = misalign_q;
  assign illegal_o    = illegal_q;
  assign br_cnt_o     = br_cnt_q;
  assign taken_cnt_o  = taken_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Self-checking bench. Two instances (FLUSH_CYCLES 2 / 32-bit
//               counters and FLUSH_CYCLES 4 / 4-bit counters) share stimulus
//               and are compared against a behavioural model each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, branch_i, jal_i, jalr_i, BrEq_i, BrLt_i;
  logic [2:0]  funct3_i;
  logic [31:0] pc_i, imm_i, rs1_i;

  logic        ready0, brun0, red0, flush0, lv0, mis0, ill0;
  logic [31:0] tgt0, link0, brc0, tkc0;
  logic        ready1, brun1, red1, flush1, lv1, mis1, ill1;
  logic [31:0] tgt1, link1;
  logic [3:0]  brc1, tkc1;

  int vecs = 0;
  int errs = 0;

  // Model state per instance.
  int          m_left [2];
  int          m_fc   [2];
  logic [31:0] m_mask [2];
  logic [31:0] m_tgt  [2];
  logic [31:0] m_link [2];
  logic [31:0] m_br   [2];
  logic [31:0] m_tk   [2];
  bit          m_red  [2];
  bit          m_lv   [2];
  bit          m_mis  [2];
  bit          m_ill  [2];

  always #5 clk_i = ~clk_i;

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_WIDTH(32)) u0 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready0),
    .branch_i(branch_i), .jal_i(jal_i), .jalr_i(jalr_i), .funct3_i(funct3_i),
    .pc_i(pc_i), .imm_i(imm_i), .rs1_i(rs1_i), .BrUn_o(brun0),
    .BrEq_i(BrEq_i), .BrLt_i(BrLt_i), .redirect_o(red0), .target_o(tgt0),
    .flush_o(flush0), .link_valid_o(lv0), .link_o(link0), .misalign_o(mis0),
    .illegal_o(ill0), .br_cnt_o(brc0), .taken_cnt_o(tkc0)
  );

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(4), .CNT_WIDTH(4)) u1 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready1),
    .branch_i(branch_i), .jal_i(jal_i), .jalr_i(jalr_i), .funct3_i(funct3_i),
    .pc_i(pc_i), .imm_i(imm_i), .rs1_i(rs1_i), .BrUn_o(brun1),
    .BrEq_i(BrEq_i), .BrLt_i(BrLt_i), .redirect_o(red1), .target_o(tgt1),
    .flush_o(flush1), .link_valid_o(lv1), .link_o(link1), .misalign_o(mis1),
    .illegal_o(ill1), .br_cnt_o(brc1), .taken_cnt_o(tkc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Branch outcome from the ISA condition table, given comparator flags.
  function automatic bit cond_taken(input logic [2:0] f3, input bit eq, input bit lt);
    bit r;
    case (f3)
      3'd0:       r = eq;
      3'd1:       r = !eq;
      3'd4, 3'd6: r = lt;
      3'd5, 3'd7: r = !lt;
      default:    r = 0;
    endcase
    return r;
  endfunction

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_red[k] = 0; m_lv[k] = 0; m_mis[k] = 0; m_ill[k] = 0;
      if (rst_i) begin
        m_left[k] = 0; m_tgt[k] = 0; m_link[k] = 0; m_br[k] = 0; m_tk[k] = 0;
      end else begin
        bit          acc;
        bit          tk;
        logic [31:0] t;
        int          kind;  // 0 none, 1 jal, 2 jalr, 3 branch
        acc = valid_i && (m_left[k] == 0);
        if (m_left[k] > 0) m_left[k]--;
        if (acc) begin
          kind = jal_i ? 1 : jalr_i ? 2 : branch_i ? 3 : 0;
          tk   = (kind == 1) || (kind == 2) ||
                 (kind == 3 && cond_taken(funct3_i, BrEq_i, BrLt_i));
          t    = (kind == 2) ? ((rs1_i + imm_i) & 32'hFFFF_FFFE) : (pc_i + imm_i);
          if (kind == 3) begin
            m_br[k] = (m_br[k] + 1) & m_mask[k];
            if (funct3_i == 3'd2 || funct3_i == 3'd3) m_ill[k] = 1;
          end
          if (tk) begin
            if ((t % 4) >= 2) m_mis[k] = 1;
            else begin
              m_red[k]  = 1;
              m_tgt[k]  = t;
              m_tk[k]   = (m_tk[k] + 1) & m_mask[k];
              m_left[k] = m_fc[k];
              if (kind != 3) begin
                m_lv[k]   = 1;
                m_link[k] = pc_i + 4;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("u0.ready",    {31'd0, ready0}, {31'd0, m_left[0] == 0});
    chk("u0.flush",    {31'd0, flush0}, {31'd0, m_left[0] > 0});
    chk("u0.redirect", {31'd0, red0},   {31'd0, m_red[0]});
    chk("u0.target",   tgt0,            m_tgt[0]);
    chk("u0.link_v",   {31'd0, lv0},    {31'd0, m_lv[0]});
    chk("u0.link",     link0,           m_link[0]);
    chk("u0.misalign", {31'd0, mis0},   {31'd0, m_mis[0]});
    chk("u0.illegal",  {31'd0, ill0},   {31'd0, m_ill[0]});
    chk("u0.br_cnt",   brc0,            m_br[0]);
    chk("u0.tk_cnt",   tkc0,            m_tk[0]);
    chk("u1.ready",    {31'd0, ready1}, {31'd0, m_left[1] == 0});
    chk("u1.flush",    {31'd0, flush1}, {31'd0, m_left[1] > 0});
    chk("u1.redirect", {31'd0, red1},   {31'd0, m_red[1]});
    chk("u1.target",   tgt1,            m_tgt[1]);
    chk("u1.link_v",   {31'd0, lv1},    {31'd0, m_lv[1]});
    chk("u1.link",     link1,           m_link[1]);
    chk("u1.misalign", {31'd0, mis1},   {31'd0, m_mis[1]});
    chk("u1.illegal",  {31'd0, ill1},   {31'd0, m_ill[1]});
    chk("u1.br_cnt",   {28'd0, brc1},   m_br[1]);
    chk("u1.tk_cnt",   {28'd0, tkc1},   m_tk[1]);
  endtask

  // One clock: check the combinational select, advance model, sample outputs.
  task automatic step();
    #1;
    chk("u0.BrUn", {31'd0, brun0}, {31'd0, funct3_i[1]});
    chk("u1.BrUn", {31'd0, brun1}, {31'd0, funct3_i[1]});
    model_edge();
    @(posedge clk_i);
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input bit b, input bit j, input bit jr,
                       input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1,
                       input bit eq, input bit lt);
    valid_i = v; branch_i = b; jal_i = j; jalr_i = jr; funct3_i = f3;
    pc_i = pc; imm_i = imm; rs1_i = rs1; BrEq_i = eq; BrLt_i = lt;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0);
  endtask

  initial begin
    int guard;
    m_fc[0] = 2;  m_mask[0] = 32'hFFFF_FFFF;
    m_fc[1] = 4;  m_mask[1] = 32'h0000_000F;
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_tgt[k] = 0; m_link[k] = 0; m_br[k] = 0; m_tk[k] = 0;
      m_red[k] = 0; m_lv[k] = 0; m_mis[k] = 0; m_ill[k] = 0;
    end
    idle();
    rst_i = 1'b1;
    @(posedge clk_i);
    step();
    step();
    rst_i = 1'b0;

    // BEQ taken: pc 0x100 + 0x20.
    drive(1, 1, 0, 0, 3'b000, 32'h100, 32'h20, 32'h0, 1, 0);
    step();
    chk("beq.target", tgt0, 32'h120);
    idle();
    step();
    step();
    step();
    step();
    chk("beq.br_cnt", brc0, 32'd1);

    // BGEU not taken with BrLt=1.
    drive(1, 1, 0, 0, 3'b111, 32'h200, 32'h40, 32'h0, 0, 1);
    step();
    idle();
    step();

    // JALR: (0x2003 + 1) & ~1 = 0x2004, link 0x44.
    drive(1, 0, 0, 1, 3'b000, 32'h40, 32'h1, 32'h2003, 0, 0);
    step();
    chk("jalr.target", tgt0, 32'h2004);
    chk("jalr.link",   link0, 32'h44);
    idle();
    for (int i = 0; i < 4; i++) step();

    // JAL to misaligned target 0x102.
    drive(1, 0, 1, 0, 3'b000, 32'h100, 32'h2, 32'h0, 0, 0);
    step();
    idle();
    step();

    // Illegal funct3 011.
    drive(1, 1, 0, 0, 3'b011, 32'h300, 32'h8, 32'h0, 1, 1);
    step();

    // Redirect, then hold a not-taken branch through the flush.
    drive(1, 1, 0, 0, 3'b001, 32'h400, 32'h10, 32'h0, 0, 0);
    step();
    drive(1, 1, 0, 0, 3'b000, 32'h500, 32'h10, 32'h0, 0, 0);
    guard = 0;
    while (!ready0 && guard < 20) begin
      step();
      guard++;
    end
    chk("hold.bound", {31'd0, ready0}, 32'd1);
    step();
    idle();
    for (int i = 0; i < 4; i++) step();

    // Reset during the second FLUSH cycle of the 4-cycle instance.
    drive(1, 0, 1, 0, 3'b000, 32'h600, 32'h20, 32'h0, 0, 0);
    step();
    idle();
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst.flush1", {31'd0, flush1}, 32'd0);
    chk("rst.ready1", {31'd0, ready1}, 32'd1);
    chk("rst.tgt1",   tgt1, 32'd0);
    chk("rst.brc1",   {28'd0, brc1}, 32'd0);
    chk("rst.tkc1",   {28'd0, tkc1}, 32'd0);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ri;
      ri = $urandom;
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
            3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC,
            (ri[0] ? ($urandom & 32'h0000_0FFC) : $urandom), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      rst_i = ($urandom_range(0, 99) == 0);
      step();
    end
    rst_i = 1'b0;
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
